// File: rtl/port_uart_bridge.sv
// port_uart_bridge: UART link standing in for the board switches/buttons on the 8-bit I/O port.
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   uart_rx    serial in, 8N1, idle high, asynchronous to clk
//   uart_tx    serial out, 8N1, idle high
//   port_out   computer output port; each change is sent over uart_tx
//   port_in    last byte received over uart_rx
//   port_write one-cycle strobe when port_in takes a new byte
//   rx_error   one-cycle pulse on a framing error
//   tx_busy    high while a frame is being transmitted
module port_uart_bridge #(
    parameter int          CLK_DIV    = 434,
    parameter logic [7:0]  PORT_RESET = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rx,
    output logic       uart_tx,
    input  logic [7:0] port_out,
    output logic [7:0] port_in,
    output logic       port_write,
    output logic       rx_error,
    output logic       tx_busy
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    localparam logic [15:0] HALF = 16'(CLK_DIV / 2 - 1);
    localparam logic [15:0] FULL = 16'(CLK_DIV - 1);

    logic [1:0]  sync_q;
    logic        rxs;
    state_e      rx_state_q, rx_state_d, tx_state_q, tx_state_d;
    logic [15:0] rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
    logic [2:0]  rx_idx_q, rx_idx_d, tx_idx_q, tx_idx_d;
    logic [7:0]  rx_sh_q, rx_sh_d, tx_byte_q, tx_byte_d, shadow_q, shadow_d;
    logic [7:0]  port_in_q, port_in_d;
    logic        write_q, write_d, err_q, err_d;

    assign rxs = sync_q[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q     <= 2'b11;
            rx_state_q <= IDLE;
            rx_cnt_q   <= '0;
            rx_idx_q   <= '0;
            rx_sh_q    <= '0;
            port_in_q  <= PORT_RESET;
            write_q    <= 1'b0;
            err_q      <= 1'b0;
            tx_state_q <= IDLE;
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_byte_q  <= '0;
            shadow_q   <= PORT_RESET;
        end else begin
            sync_q     <= {sync_q[0], uart_rx};
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_idx_q   <= rx_idx_d;
            rx_sh_q    <= rx_sh_d;
            port_in_q  <= port_in_d;
            write_q    <= write_d;
            err_q      <= err_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_idx_q   <= tx_idx_d;
            tx_byte_q  <= tx_byte_d;
            shadow_q   <= shadow_d;
        end
    end

    // Receiver: start bit is re-checked at its midpoint, then every bit is sampled mid-cell.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q - 16'd1;
        rx_idx_d   = rx_idx_q;
        rx_sh_d    = rx_sh_q;
        port_in_d  = port_in_q;
        write_d    = 1'b0;
        err_d      = 1'b0;
        case (rx_state_q)
            IDLE: begin
                rx_cnt_d = rx_cnt_q;
                if (!rxs) begin
                    rx_state_d = START;
                    rx_cnt_d   = HALF;
                end
            end
            START: if (rx_cnt_q == 16'd0) begin
                rx_state_d = rxs ? IDLE : DATA;
                rx_cnt_d   = FULL;
                rx_idx_d   = 3'd0;
            end
            DATA: if (rx_cnt_q == 16'd0) begin
                rx_sh_d    = {rxs, rx_sh_q[7:1]};
                rx_cnt_d   = FULL;
                rx_idx_d   = rx_idx_q + 3'd1;
                rx_state_d = (rx_idx_q == 3'd7) ? STOP : DATA;
            end
            default: if (rx_cnt_q == 16'd0) begin
                rx_state_d = IDLE;
                port_in_d  = rxs ? rx_sh_q : port_in_q;
                write_d    = rxs;
                err_d      = !rxs;
            end
        endcase
    end

    // Transmitter: the shadow holds the last value sent, so changes during a frame coalesce.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q - 16'd1;
        tx_idx_d   = tx_idx_q;
        tx_byte_d  = tx_byte_q;
        shadow_d   = shadow_q;
        case (tx_state_q)
            IDLE: begin
                tx_cnt_d = tx_cnt_q;
                if (port_out != shadow_q) begin
                    shadow_d   = port_out;
                    tx_byte_d  = port_out;
                    tx_state_d = START;
                    tx_cnt_d   = FULL;
                    tx_idx_d   = 3'd0;
                end
            end
            START: if (tx_cnt_q == 16'd0) begin
                tx_state_d = DATA;
                tx_cnt_d   = FULL;
            end
            DATA: if (tx_cnt_q == 16'd0) begin
                tx_cnt_d   = FULL;
                tx_idx_d   = tx_idx_q + 3'd1;
                tx_state_d = (tx_idx_q == 3'd7) ? STOP : DATA;
            end
            default: if (tx_cnt_q == 16'd0) tx_state_d = IDLE;
        endcase
    end

    // Decoded straight from state so an asserted reset forces the line idle immediately.
    assign uart_tx    = (tx_state_q == START) ? 1'b0 :
                        (tx_state_q == DATA)  ? tx_byte_q[tx_idx_q] : 1'b1;
    assign tx_busy    = tx_state_q != IDLE;
    assign port_in    = port_in_q;
    assign port_write = write_q;
    assign rx_error   = err_q;
endmodule

// File: tb/tb_port_uart_bridge.sv
// tb_port_uart_bridge: scoreboard bench for port_uart_bridge with CLK_DIV=8.
module tb_port_uart_bridge;
    localparam int DIV = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       uart_rx = 1'b1;
    logic [7:0] port_out = 8'h00;
    logic       uart_tx, port_write, rx_error, tx_busy;
    logic [7:0] port_in;

    port_uart_bridge #(.CLK_DIV(DIV), .PORT_RESET(8'h00)) dut (
        .clk(clk), .reset(reset), .uart_rx(uart_rx), .uart_tx(uart_tx),
        .port_out(port_out), .port_in(port_in), .port_write(port_write),
        .rx_error(rx_error), .tx_busy(tx_busy)
    );

    always #5 clk = ~clk;

    typedef struct {logic [7:0] b; int t0;} rx_exp_t;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         rx_err_seen = 0;
    int         rx_err_exp = 0;
    bit         tx_mon = 1'b1;
    logic       pw_prev = 1'b0;
    logic [7:0] tx_bits;
    rx_exp_t    rxq[$];
    logic [7:0] txq[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        if (stop) rxq.push_back('{b, cyc});
        else rx_err_exp++;
        uart_rx = 1'b0;
        repeat (DIV) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (DIV) @(posedge clk);
            #1;
        end
        uart_rx = stop;
        repeat (DIV) @(posedge clk);
        #1;
        uart_rx = 1'b1;
    endtask

    task automatic drain();
        int n = 0;
        while ((rxq.size() != 0 || txq.size() != 0) && n < 3000) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        check("drain_timeout", 32'(n < 3000), 1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial forever begin
        rx_exp_t e;
        int lat;
        @(negedge clk);
        if (reset) begin
            if (port_write) begin
                check("pw_width", 32'(pw_prev), 0);
                if (rxq.size() == 0) check("rx_unexpected", 1, 0);
                else begin
                    e = rxq.pop_front();
                    lat = cyc - e.t0;
                    check("rx_byte", 32'(port_in), 32'(e.b));
                    check("rx_latency", 32'(lat >= 77 && lat <= 80), 1);
                end
            end
            if (rx_error) rx_err_seen++;
        end
        pw_prev = port_write;
    end

    initial forever begin
        @(negedge clk);
        if (tx_mon && reset && uart_tx === 1'b0) begin
            repeat (DIV / 2) @(negedge clk);
            check("tx_start", 32'(uart_tx), 0);
            for (int i = 0; i < 8; i++) begin
                repeat (DIV) @(negedge clk);
                tx_bits[i] = uart_tx;
            end
            repeat (DIV) @(negedge clk);
            check("tx_stop", 32'(uart_tx), 1);
            if (txq.size() == 0) check("tx_unexpected", 1, 0);
            else check("tx_byte", 32'(tx_bits), 32'(txq.pop_front()));
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [9:0] frame;
        reset = 1'b0;
        idle(5);
        check("rst_port_in", 32'(port_in), 0);
        check("rst_port_write", 32'(port_write), 0);
        check("rst_uart_tx", 32'(uart_tx), 1);
        check("rst_tx_busy", 32'(tx_busy), 0);
        check("rst_rx_error", 32'(rx_error), 0);
        reset = 1'b1;
        idle(5);

        send_rx(8'hA5, 1'b1);
        send_rx(8'h3C, 1'b1);
        idle(20);
        check("rx_hold", 32'(port_in), 32'h3C);
        check("rx_no_err", 32'(rx_err_seen), 0);

        send_rx(8'h5A, 1'b0);
        idle(20);
        check("err_hold", 32'(port_in), 32'h3C);
        check("err_count", 32'(rx_err_seen), 32'(rx_err_exp));

        uart_rx = 1'b0;
        idle(2);
        uart_rx = 1'b1;
        idle(30);
        check("glitch_err", 32'(rx_err_seen), 32'(rx_err_exp));
        check("glitch_hold", 32'(port_in), 32'h3C);

        frame = {1'b1, 8'h7E, 1'b0};
        port_out = 8'h7E;
        txq.push_back(8'h7E);
        fork
            begin
                @(posedge clk);
                for (int i = 0; i < 10 * DIV; i++) begin
                    @(negedge clk);
                    if (i == 0) check("tx_busy_rise", 32'(tx_busy), 1);
                    check("tx_wave", 32'(uart_tx), 32'(frame[i / DIV]));
                end
            end
            begin
                idle(20);
                port_out = 8'h11;
                idle(20);
                port_out = 8'h22;
                txq.push_back(8'h22);
            end
        join
        drain();
        idle(200);
        check("coalesce_idle", 32'(tx_busy), 0);

        port_out = 8'h44;
        txq.push_back(8'h44);
        idle(20);
        port_out = 8'h11;
        idle(20);
        port_out = 8'h44;
        drain();
        idle(200);
        check("return_idle", 32'(tx_busy), 0);

        fork
            send_rx(8'h0F, 1'b1);
            begin
                port_out = 8'h81;
                txq.push_back(8'h81);
            end
        join
        drain();
        idle(20);
        check("conc_port_in", 32'(port_in), 32'h0F);

        tx_mon = 1'b0;
        port_out = 8'h5A;
        idle(30);
        @(negedge clk);
        check("pre_reset_low", 32'(uart_tx), 0);
        reset = 1'b0;
        #1;
        check("midreset_tx", 32'(uart_tx), 1);
        check("midreset_busy", 32'(tx_busy), 0);
        check("midreset_port_in", 32'(port_in), 0);
        port_out = 8'h00;
        idle(3);
        reset = 1'b1;
        idle(10);
        check("final_rx_err", 32'(rx_err_seen), 32'(rx_err_exp));
        check("final_queues", 32'(rxq.size() + txq.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
